// File: rtl/df_coeff_loader_if.sv
// Coefficient word stream between the coefficient source and the loader.
interface df_coeff_loader_if #(
  parameter int unsigned COEFF_WIDTH = 16
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [COEFF_WIDTH-1:0] wr_data;
  logic                   wr_last;
  logic                   abort;

  modport master (output wr_valid, output wr_data, output wr_last, output abort, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, input abort, output wr_ready);
endinterface

// File: rtl/df_coeff_loader.sv
// Coefficient loader: collects a framed set of N+1 taps into a shadow bank and
// commits it atomically to the active bank on a sample-boundary strobe.
module df_coeff_loader #(
  parameter int unsigned N           = 3,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned IDX_WIDTH   = 2,
  parameter logic [COEFF_WIDTH*(N+1)-1:0] RESET_COEFFS = 64'h0000_0000_0000_4000
) (
  input  logic                         clk,
  input  logic                         rst,
  df_coeff_loader_if.slave             wr,
  input  logic                         swap_en,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_coeffs,
  output logic                         coeff_update,
  output logic                         busy,
  output logic                         err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

  state_t                        state;
  logic [IDX_WIDTH-1:0]          idx;
  logic [N:0][COEFF_WIDTH-1:0]   shadow;
  logic                          ready_q;
  logic                          xfer;

  // Ready is registered with the state; abort masks it combinationally so an
  // aborting cycle never also accepts a word.
  assign wr.wr_ready = ready_q && !wr.abort;
  assign xfer        = wr.wr_valid && wr.wr_ready;

  // Frame sequencing, shadow fill, atomic commit and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      shadow        <= '0;
      packed_coeffs <= RESET_COEFFS;
      coeff_update  <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      coeff_update <= 1'b0;
      err          <= 1'b0;
      ready_q      <= 1'b1;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (xfer) begin
            if (wr.wr_last) begin
              // A one-word frame is short; drop it without touching the shadow.
              err <= 1'b1;
            end else begin
              shadow[0] <= wr.wr_data;
              idx       <= IDX_WIDTH'(1);
              state     <= LOAD;
              busy      <= 1'b1;
            end
          end
        end

        LOAD: begin
          busy <= 1'b1;
          if (wr.abort) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else if (xfer) begin
            shadow[idx] <= wr.wr_data;
            if (idx == LAST_IDX) begin
              if (wr.wr_last) begin
                state   <= PENDING;
                ready_q <= 1'b0;
              end else begin
                // Overrun: the frame has too many words.
                err   <= 1'b1;
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
              end
            end else if (wr.wr_last) begin
              // Short frame: last marker arrived before slot N.
              err   <= 1'b1;
              state <= IDLE;
              idx   <= '0;
              busy  <= 1'b0;
            end else begin
              idx <= idx + IDX_WIDTH'(1);
            end
          end
        end

        PENDING: begin
          busy    <= 1'b1;
          ready_q <= 1'b0;
          if (wr.abort) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end else if (swap_en) begin
            packed_coeffs <= shadow;
            coeff_update  <= 1'b1;
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            ready_q       <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
